// File: rtl/ram_arb.sv
// ram_arb: two-master arbiter/sequencer in front of the single-port data RAM.
// One access granted per cycle; 1-cycle read data routed back to its owner.
module ram_arb #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MW        = 4,
   parameter int MAX_BURST = 4,
   parameter int PRIO_MODE = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [MW-1:0] m0_wem,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [MW-1:0] m1_wem,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [MW-1:0] ram_wem,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic          last;
   logic [CW-1:0] run_cnt;
   logic [CW-1:0] starve_cnt;
   logic          rd_pend;
   logic          rd_own;
   logic          pick1;
   logic          g0;
   logic          g1;
   logic          any_gnt;

   // Contention winner: m1 preferred when pick1 is set and both request.
   always_comb begin
      pick1 = 1'b0;
      if (PRIO_MODE != 0) begin
         pick1 = (starve_cnt == BMAX);
      end else if ((run_cnt != '0) && (run_cnt < BMAX)) begin
         pick1 = last;
      end else begin
         pick1 = ~last;
      end
      g0      = rst_n & m0_req & (~m1_req | ~pick1);
      g1      = rst_n & m1_req & (~m0_req | pick1);
      any_gnt = g0 | g1;
   end

   assign m0_gnt = g0;
   assign m1_gnt = g1;

   // RAM port mux from the granted master, idle bus when nothing granted.
   always_comb begin
      ram_cs   = any_gnt;
      ram_we   = 1'b0;
      ram_wem  = '0;
      ram_addr = '0;
      ram_din  = '0;
      if (g0) begin
         ram_we   = m0_we;
         ram_wem  = m0_wem;
         ram_addr = m0_addr;
         ram_din  = m0_wdata;
      end else if (g1) begin
         ram_we   = m1_we;
         ram_wem  = m1_wem;
         ram_addr = m1_addr;
         ram_din  = m1_wdata;
      end
   end

   // Burst tracking: last winner and length of its current grant run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last    <= 1'b1;
         run_cnt <= '0;
      end else if (any_gnt) begin
         last <= g1;
         if ((g1 == last) && (run_cnt != '0)) begin
            if (run_cnt != BMAX) begin
               run_cnt <= run_cnt + ONE;
            end
         end else begin
            run_cnt <= ONE;
         end
      end else begin
         run_cnt <= '0;
      end
   end

   // Starvation guard: consecutive cycles m1 waited without a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (m1_req && !g1) begin
         if (starve_cnt != BMAX) begin
            starve_cnt <= starve_cnt + ONE;
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   // Read pipeline: remember that a read went out and who owns the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= 1'b0;
         rd_own  <= 1'b0;
      end else if (any_gnt && !ram_we) begin
         rd_pend <= 1'b1;
         rd_own  <= g1;
      end else begin
         rd_pend <= 1'b0;
      end
   end

   assign m0_rvalid = rst_n & rd_pend & ~rd_own;
   assign m1_rvalid = rst_n & rd_pend & rd_own;
   assign m0_rdata  = ram_dout;
   assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: checks a round-robin and a fixed-priority ram_arb
// against a history-based model, plus directed literal scenarios.
module tb_ram_arb;

   localparam int MB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        ram_clr;
   logic        mreq  [2][2];
   logic        mwe   [2][2];
   logic [3:0]  mwem  [2][2];
   logic [31:0] maddr [2][2];
   logic [31:0] mwd   [2][2];
   logic        mgnt  [2][2];
   logic        mrv   [2][2];
   logic [31:0] mrd   [2][2];
   logic        gseen [2][2];
   logic        cs    [2];
   logic        we    [2];
   logic [3:0]  wem   [2];
   logic [31:0] addr  [2];
   logic [31:0] din   [2];
   logic [31:0] dout  [2];

   ram_arb #(.MAX_BURST(MB), .PRIO_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(mreq[0][0]), .m0_we(mwe[0][0]), .m0_wem(mwem[0][0]),
      .m0_addr(maddr[0][0]), .m0_wdata(mwd[0][0]),
      .m0_gnt(mgnt[0][0]), .m0_rvalid(mrv[0][0]), .m0_rdata(mrd[0][0]),
      .m1_req(mreq[0][1]), .m1_we(mwe[0][1]), .m1_wem(mwem[0][1]),
      .m1_addr(maddr[0][1]), .m1_wdata(mwd[0][1]),
      .m1_gnt(mgnt[0][1]), .m1_rvalid(mrv[0][1]), .m1_rdata(mrd[0][1]),
      .ram_cs(cs[0]), .ram_we(we[0]), .ram_wem(wem[0]),
      .ram_addr(addr[0]), .ram_din(din[0]), .ram_dout(dout[0])
   );

   ram_arb #(.MAX_BURST(MB), .PRIO_MODE(1)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .m0_req(mreq[1][0]), .m0_we(mwe[1][0]), .m0_wem(mwem[1][0]),
      .m0_addr(maddr[1][0]), .m0_wdata(mwd[1][0]),
      .m0_gnt(mgnt[1][0]), .m0_rvalid(mrv[1][0]), .m0_rdata(mrd[1][0]),
      .m1_req(mreq[1][1]), .m1_we(mwe[1][1]), .m1_wem(mwem[1][1]),
      .m1_addr(maddr[1][1]), .m1_wdata(mwd[1][1]),
      .m1_gnt(mgnt[1][1]), .m1_rvalid(mrv[1][1]), .m1_rdata(mrd[1][1]),
      .ram_cs(cs[1]), .ram_we(we[1]), .ram_wem(wem[1]),
      .ram_addr(addr[1]), .ram_din(din[1]), .ram_dout(dout[1])
   );

   function automatic logic [31:0] bmask(input logic [3:0] w);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{w[b]}};
      return m;
   endfunction

   // RAM behaviour seen by each arbiter: masked writes, 1-cycle reads.
   logic [31:0] ram [2][64];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[k][i] <= '0;
         end else if (cs[k]) begin
            if (we[k])
               ram[k][addr[k][7:2]] <=
                  (ram[k][addr[k][7:2]] & ~bmask(wem[k])) |
                  (din[k] & bmask(wem[k]));
            else
               dout[k] <= ram[k][addr[k][7:2]];
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: grant history (most recent first), m1 wait
   // history, memory image and the outstanding read.
   int          hw    [2][8];
   int          hs    [2][8];
   int          lastw [2];
   logic        pend  [2];
   int          own   [2];
   logic [31:0] pdata [2];
   logic [31:0] mm    [2][64];

   function automatic int exp_win(input int k, input logic r0,
                                  input logic r1);
      int s;
      s = 0;
      if (!r0 && !r1) return -1;
      if (!r1) return 0;
      if (!r0) return 1;
      if (k == 1) begin
         while (s < 8 && hs[k][s] != 0) s++;
         return (s >= MB) ? 1 : 0;
      end
      if (hw[k][0] < 0) return 1 - lastw[k];
      while (s < 8 && hw[k][s] == hw[k][0]) s++;
      return (s < MB) ? hw[k][0] : 1 - hw[k][0];
   endfunction

   task automatic model_reset(input int k);
      for (int i = 0; i < 8; i++) begin
         hw[k][i] = -1;
         hs[k][i] = 0;
      end
      lastw[k] = 1;
      pend[k]  = 1'b0;
      own[k]   = 0;
   endtask

   task automatic cycle_check(input int k);
      logic        r0, r1, ewe;
      logic [3:0]  ewem;
      logic [31:0] ea, ed;
      int          w;
      r0 = mreq[k][0];
      r1 = mreq[k][1];
      w  = exp_win(k, r0, r1);
      ewe = 1'b0; ewem = '0; ea = '0; ed = '0;
      if (w >= 0) begin
         ewe  = mwe[k][w];
         ewem = mwem[k][w];
         ea   = maddr[k][w];
         ed   = mwd[k][w];
      end
      chk($sformatf("gnt[%0d]", k), {mgnt[k][0], mgnt[k][1]},
          {w == 0, w == 1});
      chk($sformatf("ram_ctl[%0d]", k), {cs[k], we[k], wem[k]},
          {w >= 0, ewe, ewem});
      chk($sformatf("ram_addr[%0d]", k), addr[k], ea);
      chk($sformatf("ram_din[%0d]", k), din[k], ed);
      chk($sformatf("rvalid[%0d]", k), {mrv[k][0], mrv[k][1]},
          {pend[k] && own[k] == 0, pend[k] && own[k] == 1});
      if (pend[k])
         chk($sformatf("rdata[%0d]", k), mrd[k][own[k]], pdata[k]);
      pend[k] = 1'b0;
      if (w >= 0) begin
         if (ewe) begin
            mm[k][ea[7:2]] = (mm[k][ea[7:2]] & ~bmask(ewem)) |
                             (ed & bmask(ewem));
         end else begin
            pend[k]  = 1'b1;
            own[k]   = w;
            pdata[k] = mm[k][ea[7:2]];
         end
         lastw[k] = w;
      end
      for (int i = 7; i > 0; i--) begin
         hw[k][i] = hw[k][i-1];
         hs[k][i] = hs[k][i-1];
      end
      hw[k][0] = w;
      hs[k][0] = (r1 && w != 1) ? 1 : 0;
   endtask

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ram_clr)
            for (int i = 0; i < 64; i++) mm[k][i] = '0;
         if (!rst_n) begin
            chk($sformatf("reset_quiet[%0d]", k),
                {mgnt[k][0], mgnt[k][1], mrv[k][0], mrv[k][1], cs[k]},
                '0);
            model_reset(k);
         end else begin
            cycle_check(k);
         end
      end
   end

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic rq, input logic w,
                        input logic [3:0] wm, input logic [31:0] a,
                        input logic [31:0] d);
      for (int k = 0; k < 2; k++) begin
         mreq[k][m]  = rq;
         mwe[k][m]   = w;
         mwem[k][m]  = wm;
         maddr[k][m] = a;
         mwd[k][m]   = d;
      end
   endtask

   task automatic idle_all;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   int rr_pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
   int fx_pat [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

   initial begin
      ram_clr = 1'b1;
      rst_n   = 1'b0;
      idle_all();
      for (int k = 0; k < 2; k++) begin
         gseen[k][0] = 1'b0;
         gseen[k][1] = 1'b0;
      end
      nxt();
      ram_clr = 1'b0;
      nxt();
      nxt();
      rst_n = 1'b1;

      // lone m0 read
      nxt();
      drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      #5;
      for (int k = 0; k < 2; k++)
         chk("t1_gnt", {mgnt[k][0], cs[k], we[k]}, 3'b110);
      nxt();
      idle_all();
      #5;
      for (int k = 0; k < 2; k++) begin
         chk("t1_rvalid", {mrv[k][0], mrv[k][1]}, 2'b10);
         chk("t1_rdata", mrd[k][0], 32'h0);
      end

      // masked write then read-back by m1
      nxt();
      drive(0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
      #5;
      for (int k = 0; k < 2; k++)
         chk("t4_write", {we[k], wem[k], mrv[k][0], mrv[k][1]},
             {1'b1, 4'b0011, 2'b00});
      nxt();
      idle_all();
      drive(1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      #5;
      for (int k = 0; k < 2; k++)
         chk("t4_gnt", {mgnt[k][1], mgnt[k][0]}, 2'b10);
      nxt();
      idle_all();
      #5;
      for (int k = 0; k < 2; k++) begin
         chk("t4_rvalid", mrv[k][1], 1'b1);
         chk("t4_rdata", mrd[k][1], 32'h0000BEEF);
      end

      // alternating back-to-back reads
      nxt();
      drive(0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h11111111);
      nxt();
      drive(0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h22222222);
      nxt();
      drive(0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h33333333);
      nxt();
      drive(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      nxt();
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      #5;
      for (int k = 0; k < 2; k++)
         chk("t5_m0_first", {mrv[k][0], mrd[k][0]}, {1'b1, 32'h11111111});
      nxt();
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
      #5;
      for (int k = 0; k < 2; k++)
         chk("t5_m1", {mrv[k][1], mrd[k][1]}, {1'b1, 32'h22222222});
      nxt();
      idle_all();
      #5;
      for (int k = 0; k < 2; k++)
         chk("t5_m0_last", {mrv[k][0], mrd[k][0]}, {1'b1, 32'h33333333});

      // reset while a read is pending
      nxt();
      drive(0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      nxt();
      idle_all();
      rst_n = 1'b0;
      #5;
      for (int k = 0; k < 2; k++)
         chk("t6_in_reset", {mrv[k][0], mrv[k][1]}, 2'b00);
      nxt();
      rst_n = 1'b1;
      #5;
      for (int k = 0; k < 2; k++)
         chk("t6_after", {mrv[k][0], mrv[k][1]}, 2'b00);

      // both masters contending continuously
      nxt();
      drive(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      for (int c = 0; c < 12; c++) begin
         #5;
         chk($sformatf("rr_pat%0d", c), {mgnt[0][1], mgnt[0][0]},
             {rr_pat[c] == 1, rr_pat[c] == 0});
         chk($sformatf("fx_pat%0d", c), {mgnt[1][1], mgnt[1][0]},
             {fx_pat[c] == 1, fx_pat[c] == 0});
         nxt();
      end
      idle_all();

      // randomized traffic, requests held until granted
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
               if (!mreq[k][m] || gseen[k][m]) begin
                  mreq[k][m]  = ($urandom_range(0, 99) < 65);
                  mwe[k][m]   = 1'($urandom_range(0, 1));
                  mwem[k][m]  = 4'($urandom_range(0, 15));
                  maddr[k][m] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                  mwd[k][m]   = $urandom;
               end
            end
         end
         if (c == 1500) rst_n = 1'b0;
         if (c == 1501) rst_n = 1'b1;
         #5;
         for (int k = 0; k < 2; k++) begin
            gseen[k][0] = mgnt[k][0];
            gseen[k][1] = mgnt[k][1];
         end
         nxt();
      end
      idle_all();
      nxt();
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
